// File: rtl/uadd_pkg.sv
// Shared types for the unary-adder scheduler: FSM state encoding,
// the native adder width and the matching binary sum type.
package uadd_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2,
    RESP  = 2'd3
  } uadd_st_e;

  localparam int UADD_W = 6;

  typedef logic [UADD_W:0] uadd_sum_t;

endpackage

// File: rtl/uadd_rr_arb.sv
// Round-robin arbiter: the first set request at or after ptr_i (wrapping)
// wins; produces a one-hot grant, its encoded index and an any-request flag.
module uadd_rr_arb #(
  parameter int NREQ = 2,
  parameter int IDW  = 1
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [IDW-1:0]  ptr_i,
  output logic [NREQ-1:0] gnt_o,
  output logic [IDW-1:0]  idx_o,
  output logic            any_o
);

  logic [IDW:0] cand_s;

  // Scan candidates ptr, ptr+1, ... modulo NREQ and keep the first requester.
  always_comb begin
    cand_s = '0;
    idx_o  = '0;
    any_o  = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      cand_s = {1'b0, ptr_i} + (IDW+1)'(i);
      if (cand_s >= (IDW+1)'(NREQ)) begin
        cand_s = cand_s - (IDW+1)'(NREQ);
      end else begin
        cand_s = cand_s;
      end
      if (!any_o && req_i[cand_s[IDW-1:0]]) begin
        any_o = 1'b1;
        idx_o = cand_s[IDW-1:0];
      end else begin
        any_o = any_o;
      end
    end
  end

  // Decode the winning index into a one-hot grant vector.
  always_comb begin
    gnt_o = '0;
    if (any_o) begin
      gnt_o[idx_o] = 1'b1;
    end else begin
      gnt_o = '0;
    end
  end

endmodule

// File: rtl/unary_add_sched.sv
// Scheduler in front of one unary adder. Grants one requester at a time,
// streams its operands as unary pulses (read phase), counts the adder's
// dout pulses (write phase) and returns the binary sum with the carry.
// Optional build macro UADD_SCHED_CHECK_EN adds a sticky self-check (err_o).
module unary_add_sched
  import uadd_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int W    = UADD_W,
  parameter int IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req_valid_i,
  output logic [NREQ-1:0]   req_ready_o,
  input  logic [NREQ*W-1:0] req_a_i,
  input  logic [NREQ*W-1:0] req_b_i,
  output logic              rsp_valid_o,
  input  logic              rsp_ready_i,
  output logic [IDW-1:0]    rsp_id_o,
  output logic [W:0]        rsp_sum_o,
  output logic              add_a_o,
  output logic              add_b_o,
  output logic              add_en_o,
  output logic              add_rw_o,
  input  logic              add_dout_i,
  input  logic              add_c_i,
  output logic              err_o
);

  uadd_st_e        state_q;
  logic [IDW-1:0]  rr_ptr_q, id_q, rsp_id_q;
  logic [W-1:0]    a_rem_q, b_rem_q, pcnt_q;
  logic            carry_q, dcyc0_q;
  logic            rsp_valid_q;
  logic [W:0]      rsp_sum_q;
  logic            add_a_q, add_b_q, add_en_q, add_rw_q;

  logic [NREQ-1:0] gnt_s;
  logic [IDW-1:0]  gnt_idx_s, ptr_nxt_s;
  logic            any_s;
  logic [W-1:0]    a_sel_s, b_sel_s, a_dec_s, b_dec_s;

`ifdef UADD_SCHED_CHECK_EN
  logic [W-1:0]    a_op_q, b_op_q;
  logic            err_q;
  logic [W:0]      ref_sum_s;
  assign ref_sum_s = {1'b0, a_op_q} + {1'b0, b_op_q};
  assign err_o     = err_q;
`else
  assign err_o     = 1'b0;
`endif

  uadd_rr_arb #(.NREQ(NREQ), .IDW(IDW)) u_arb (
    .req_i (req_valid_i),
    .ptr_i (rr_ptr_q),
    .gnt_o (gnt_s),
    .idx_o (gnt_idx_s),
    .any_o (any_s)
  );

  // Grant is only offered while idle; the requester sees it in the same cycle.
  assign req_ready_o = (state_q == IDLE) ? gnt_s : '0;

  assign ptr_nxt_s = (gnt_idx_s == IDW'(NREQ - 1)) ? '0 : gnt_idx_s + IDW'(1);
  assign a_dec_s   = a_rem_q - {{(W-1){1'b0}}, (a_rem_q != '0)};
  assign b_dec_s   = b_rem_q - {{(W-1){1'b0}}, (b_rem_q != '0)};

  assign rsp_valid_o = rsp_valid_q;
  assign rsp_id_o    = rsp_id_q;
  assign rsp_sum_o   = rsp_sum_q;
  assign add_a_o     = add_a_q;
  assign add_b_o     = add_b_q;
  assign add_en_o    = add_en_q;
  assign add_rw_o    = add_rw_q;

  // Select the granted requester's operands (grant is one-hot or zero).
  always_comb begin
    a_sel_s = '0;
    b_sel_s = '0;
    for (int i = 0; i < NREQ; i++) begin
      a_sel_s = a_sel_s | (req_a_i[i*W +: W] & {W{gnt_s[i]}});
      b_sel_s = b_sel_s | (req_b_i[i*W +: W] & {W{gnt_s[i]}});
    end
  end

  // Scheduler FSM with registered adder drive and response outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      rr_ptr_q    <= '0;
      id_q        <= '0;
      a_rem_q     <= '0;
      b_rem_q     <= '0;
      pcnt_q      <= '0;
      carry_q     <= 1'b0;
      dcyc0_q     <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_sum_q   <= '0;
      add_a_q     <= 1'b0;
      add_b_q     <= 1'b0;
      add_en_q    <= 1'b0;
      add_rw_q    <= 1'b0;
`ifdef UADD_SCHED_CHECK_EN
      a_op_q      <= '0;
      b_op_q      <= '0;
      err_q       <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (any_s) begin
            a_rem_q  <= a_sel_s;
            b_rem_q  <= b_sel_s;
            id_q     <= gnt_idx_s;
            carry_q  <= 1'b0;
            pcnt_q   <= '0;
            rr_ptr_q <= ptr_nxt_s;
`ifdef UADD_SCHED_CHECK_EN
            a_op_q   <= a_sel_s;
            b_op_q   <= b_sel_s;
`endif
            add_en_q <= 1'b1;
            if ((a_sel_s != '0) || (b_sel_s != '0)) begin
              state_q  <= READ;
              add_rw_q <= 1'b0;
              add_a_q  <= (a_sel_s != '0);
              add_b_q  <= (b_sel_s != '0);
            end else begin
              state_q  <= DRAIN;
              dcyc0_q  <= 1'b1;
              add_rw_q <= 1'b1;
              add_a_q  <= 1'b0;
              add_b_q  <= 1'b0;
            end
          end else begin
            state_q <= IDLE;
          end
        end
        READ: begin
          // Carry is a registered adder output, so keep sampling every cycle.
          carry_q <= carry_q | add_c_i;
          a_rem_q <= a_dec_s;
          b_rem_q <= b_dec_s;
          if ((a_dec_s == '0) && (b_dec_s == '0)) begin
            state_q  <= DRAIN;
            dcyc0_q  <= 1'b1;
            add_rw_q <= 1'b1;
            add_a_q  <= 1'b0;
            add_b_q  <= 1'b0;
          end else begin
            add_a_q  <= (a_dec_s != '0);
            add_b_q  <= (b_dec_s != '0);
          end
        end
        DRAIN: begin
          if (dcyc0_q) begin
            // dout is stale here; catch the carry from the last read cycle.
            carry_q <= carry_q | add_c_i;
            dcyc0_q <= 1'b0;
          end else if (add_dout_i) begin
            pcnt_q  <= pcnt_q + {{(W-1){1'b0}}, 1'b1};
          end else begin
            rsp_sum_q   <= {carry_q, pcnt_q};
            rsp_id_q    <= id_q;
            rsp_valid_q <= 1'b1;
            add_en_q    <= 1'b0;
            add_rw_q    <= 1'b0;
            state_q     <= RESP;
`ifdef UADD_SCHED_CHECK_EN
            if ({carry_q, pcnt_q} != ref_sum_s) begin
              err_q <= 1'b1;
            end else begin
              err_q <= err_q;
            end
`endif
          end
        end
        RESP: begin
          if (rsp_ready_i) begin
            rsp_valid_q <= 1'b0;
            state_q     <= IDLE;
          end else begin
            rsp_valid_q <= 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_unary_add_sched.sv
// Randomized scoreboard bench for unary_add_sched with a behavioural adder.
module tb_unary_add_sched;

  localparam int NREQ = 2;
  localparam int W    = 6;
  localparam int IDW  = 1;

  logic              clk, rst_n;
  logic [NREQ-1:0]   req_valid, req_ready;
  logic [NREQ*W-1:0] req_a, req_b;
  logic              rsp_valid, rsp_ready;
  logic [IDW-1:0]    rsp_id;
  logic [W:0]        rsp_sum;
  logic              add_a, add_b, add_en, add_rw, add_dout, add_c, err;

  unary_add_sched #(.NREQ(NREQ), .W(W), .IDW(IDW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid_i(req_valid), .req_ready_o(req_ready),
    .req_a_i(req_a), .req_b_i(req_b),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
    .rsp_id_o(rsp_id), .rsp_sum_o(rsp_sum),
    .add_a_o(add_a), .add_b_o(add_b), .add_en_o(add_en), .add_rw_o(add_rw),
    .add_dout_i(add_dout), .add_c_i(add_c), .err_o(err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- behavioural unary adder ----------------
  logic [W-1:0] acnt;
  logic         adout, ac;
  int           inj_req = 0, inj_done = 0, inj_mon = 0;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acnt <= '0; adout <= 1'b0; ac <= 1'b0;
    end else if (add_en && !add_rw) begin
      {ac, acnt} <= {1'b0, acnt} + {6'd0, add_a} + {6'd0, add_b};
      adout <= 1'b0;
    end else if (add_en && add_rw) begin
      ac <= 1'b0;
      if (acnt != '0) begin
        adout <= 1'b1; acnt <= acnt - 6'd1;
      end else if (inj_req != inj_done) begin
        adout <= 1'b1; inj_done <= inj_req;
      end else begin
        adout <= 1'b0;
      end
    end else begin
      ac <= 1'b0; adout <= 1'b0;
    end
  end
  assign add_dout = adout;
  assign add_c    = ac;

  // ---------------- checking infrastructure ----------------
  int n_cmp = 0, n_bad = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input longint act, input longint req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  typedef struct { int id; int sum; int a; int b; int lat; int gcyc; } exp_t;
  exp_t exp_q[$];
  int   grant_log[$];
  int   ptr_m;
  int   rd_len, a_ones, b_ones, order_bad;
  bit   a_seen0, b_seen0, pv, pr;
  int   pid, psum;

  // Monitor: reference arbitration, scoreboard push on grant, compare on response.
  always @(negedge clk) begin : mon
    int w, exp_rdy, s, mx, ex;
    exp_t e;
    if (!rst_n) begin
      exp_q.delete(); ptr_m = 0; pv = 0; pr = 0;
    end else begin
      exp_rdy = 0; w = -1;
      if (exp_q.size() == 0 && req_valid != '0) begin
        for (int k = 0; k < NREQ; k++) begin
          if (w < 0 && req_valid[(ptr_m + k) % NREQ]) w = (ptr_m + k) % NREQ;
        end
        exp_rdy = 1 << w;
      end
      if (exp_rdy != 0 || req_ready != '0) chk("grant", int'(req_ready), exp_rdy);
      if (exp_rdy != 0 && req_ready != '0) begin
        ex = (inj_req != inj_mon) ? 1 : 0;
        inj_mon = inj_req;
        e.id = w; e.a = int'(req_a[w*W +: W]); e.b = int'(req_b[w*W +: W]);
        s = e.a + e.b; mx = (e.a > e.b) ? e.a : e.b;
        e.sum = s + ex;
        e.lat = 1 + mx + (s % 64) + ex + 2;
        e.gcyc = cyc;
        exp_q.push_back(e);
        grant_log.push_back(w);
        ptr_m = (w + 1) % NREQ;
        rd_len = 0; a_ones = 0; b_ones = 0; order_bad = 0; a_seen0 = 0; b_seen0 = 0;
      end
      if (add_en && !add_rw) begin
        rd_len++;
        if (add_a) begin a_ones++; if (a_seen0) order_bad++; end else a_seen0 = 1;
        if (add_b) begin b_ones++; if (b_seen0) order_bad++; end else b_seen0 = 1;
      end
      if (rsp_valid && !pv) begin
        if (exp_q.size() == 0) chk("unexpected_rsp", 1, 0);
        else begin
          e = exp_q[0];
          mx = (e.a > e.b) ? e.a : e.b;
          chk("rsp_id", rsp_id, e.id);
          chk("rsp_sum", rsp_sum, e.sum);
          chk("latency", cyc - e.gcyc, e.lat);
          chk("read_len", rd_len, mx);
          chk("a_pulses", a_ones, e.a);
          chk("b_pulses", b_ones, e.b);
          chk("pulse_order", order_bad, 0);
        end
      end
      if (rsp_valid) chk("idle_adder_no_grant", int'({add_en, req_ready}), 0);
      if (pv && !pr) begin
        chk("hold_valid", rsp_valid, 1);
        chk("hold_id", rsp_id, pid);
        chk("hold_sum", rsp_sum, psum);
      end
      if (rsp_valid && rsp_ready && exp_q.size() > 0) void'(exp_q.pop_front());
      pv = rsp_valid; pr = rsp_ready; pid = int'(rsp_id); psum = int'(rsp_sum);
    end
  end

  // ---------------- response-ready driver ----------------
  int ready_mode = 0;
  initial begin : rdy
    int vcnt;
    vcnt = 0;
    rsp_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (rsp_valid) vcnt++; else vcnt = 0;
      case (ready_mode)
        0:       rsp_ready = 1'b1;
        1:       rsp_ready = 1'($urandom_range(0, 1));
        default: rsp_ready = (vcnt >= 6);
      endcase
    end
  end

  // ---------------- stimulus ----------------
  bit [NREQ-1:0] reload;
  int accepted = 0;

  function automatic int rnd_op();
    case ($urandom_range(0, 7))
      0:       return 0;
      1:       return 63;
      default: return int'($urandom_range(0, 63));
    endcase
  endfunction

  task automatic load(input int r, input int a, input int b);
    req_a[r*W +: W] = W'(a);
    req_b[r*W +: W] = W'(b);
    req_valid[r]    = 1'b1;
  endtask

  task automatic step();
    logic [NREQ-1:0] acc;
    @(negedge clk); acc = req_valid & req_ready;
    @(posedge clk); #1;
    for (int r = 0; r < NREQ; r++) begin
      if (acc[r]) begin
        accepted++;
        if (reload[r]) load(r, rnd_op(), rnd_op());
        else req_valid[r] = 1'b0;
      end
    end
  endtask

  task automatic drain_all(input int budget);
    int n;
    n = 0;
    while ((req_valid != '0 || exp_q.size() != 0 || rsp_valid) && n < budget) begin
      step(); n++;
    end
    if (n >= budget) chk("drain_timeout", 1, 0);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_req_ready"}, req_ready, 0);
    chk({tag, "_rsp_valid"}, rsp_valid, 0);
    chk({tag, "_rsp_id"}, rsp_id, 0);
    chk({tag, "_rsp_sum"}, rsp_sum, 0);
    chk({tag, "_add_ports"}, int'({add_a, add_b, add_en, add_rw}), 0);
    chk({tag, "_err"}, err, 0);
  endtask

  initial begin : watchdog
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int n, g0;
    rst_n = 1'b0; req_valid = '0; req_a = '0; req_b = '0; reload = '0;
    #2 chk_reset_outputs("reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // directed operand cases
    load(0, 3, 5);   drain_all(300);
    load(1, 63, 63); drain_all(300);
    load(0, 40, 30); drain_all(300);
    load(1, 0, 0);   drain_all(300);
    load(0, 63, 1);  drain_all(300);
    load(1, 0, 63);  drain_all(300);

    // both requesters held: grants must alternate
    reload = '1; g0 = grant_log.size();
    load(0, rnd_op(), rnd_op()); load(1, rnd_op(), rnd_op());
    n = 0;
    while (grant_log.size() < g0 + 4 && n < 2000) begin step(); n++; end
    reload = '0; req_valid = '0;
    drain_all(600);
    if (grant_log.size() >= g0 + 4) begin
      for (int k = 0; k < 4; k++) chk("alternate", grant_log[g0 + k], k % 2);
    end else chk("alternate_count", grant_log.size() - g0, 4);

    // back-pressure with another requester waiting
    ready_mode = 2;
    load(0, 12, 9); load(1, 5, 20);
    drain_all(600);
    ready_mode = 0;

    // reset in the middle of the write phase
    load(0, 20, 10);
    n = 0;
    while (!(add_en && add_rw) && n < 200) begin step(); n++; end
    if (n >= 200) chk("reach_drain", 0, 1);
    step(); step();
    #2 rst_n = 1'b0; req_valid = '0;
    #1 chk_reset_outputs("midreset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    load(1, 7, 9); drain_all(300);

    // randomized traffic with random back-pressure
    ready_mode = 1; reload = '1; g0 = accepted;
    load(0, rnd_op(), rnd_op()); load(1, rnd_op(), rnd_op());
    n = 0;
    while (accepted < g0 + 40 && n < 20000) begin step(); n++; end
    reload = '0; req_valid = '0;
    drain_all(2000);
    ready_mode = 0;

`ifdef UADD_SCHED_CHECK_EN
    chk("err_clean", err, 0);
    inj_req++;
    load(0, 3, 5); drain_all(300);
    chk("err_set", err, 1);
    load(1, 1, 1); drain_all(300);
    chk("err_sticky", err, 1);
    @(negedge clk); rst_n = 1'b0;
    #1 chk("err_reset", err, 0);
    @(negedge clk); rst_n = 1'b1;
`else
    chk("err_tied_low", err, 0);
`endif

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
